x2050_ifetch_seq: RTL and testbench

// - Instruction-fetch sequencer for the 2050 datapath: owns IAR, reads storage words, extracts one
//   2/4/6-byte instruction (halfword-aligned, may straddle a word), hands it downstream with ILC.
// - Sits upstream of the fetch-status logic: supplies IAR, invalid-address and T-reg word, and

---
 rtl/x2050_pkg.sv | 28 ++
 rtl/x2050_ins_align.sv | 25 ++
 rtl/x2050_ifetch_seq.sv | 181 ++++++++++++++++++
 tb/tb_x2050_ifetch_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/x2050_pkg.sv
// Shared types and constants for the 2050 instruction-fetch sequencer.
package x2050_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq0,
    StReq1,
    StPresent,
    StFault,
    StDrain
  } fetch_state_e;

  localparam logic [3:0] INT_ADDRESSING    = 4'h5;
  localparam logic [3:0] INT_SPECIFICATION = 4'h6;

  // Instruction length in halfwords from opcode bits [7:6]: RR=1, RX/RS=2, SS=3.
  function automatic logic [1:0] ilen(input logic [1:0] op_hi);
    logic [1:0] n;
    unique case (op_hi)
      2'b00:   n = 2'd1;
      2'b11:   n = 2'd3;
      default: n = 2'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/x2050_ins_align.sv
// Extracts a left-justified instruction from up to two storage words.
module x2050_ins_align (
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  input  logic        i_iar1,
  input  logic [1:0]  i_ilc,
  output logic [47:0] o_ins
);

  logic [63:0] w_stream;
  logic [47:0] w_mask;

  // Byte stream starting at the instruction, then keep only ILC halfwords.
  always_comb begin
    w_stream = i_iar1 ? {i_word0[15:0], i_word1, 16'h0000} : {i_word0, i_word1};
    unique case (i_ilc)
      2'd1:    w_mask = 48'hFFFF_0000_0000;
      2'd2:    w_mask = 48'hFFFF_FFFF_0000;
      2'd3:    w_mask = 48'hFFFF_FFFF_FFFF;
      default: w_mask = 48'h0;
    endcase
    o_ins = w_stream[63:16] & w_mask;
  end

endmodule

// File: rtl/x2050_ifetch_seq.sv
// Instruction-fetch sequencer: owns IAR, fetches one or two storage words per instruction,
// presents the aligned instruction with its ILC, and latches program-check faults.
module x2050_ifetch_seq
  import x2050_pkg::*;
#(
  parameter logic [23:0] STORE_SIZE = 24'h040000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_branch,
  input  logic [23:0] i_branch_iar,
  input  logic        i_hold,
  output logic        o_mem_req,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_ins_valid,
  input  logic        i_ins_ready,
  output logic [47:0] o_ins,
  output logic [1:0]  o_ilc,
  output logic [23:0] o_iar,
  output logic [31:0] o_t_reg,
  output logic        o_invalid_address,
  output logic        o_refetch,
  output logic        o_pgm_int,
  output logic [3:0]  o_int_code
);

  fetch_state_e r_state, w_state_d;
  logic [23:0]  r_iar, w_iar_d;
  logic [23:0]  r_mem_addr, w_mem_addr_d;
  logic [31:0]  r_t_reg, w_t_reg_d;
  logic [31:0]  r_word0, w_word0_d;
  logic [31:0]  r_word1, w_word1_d;
  logic [1:0]   r_ilc, w_ilc_d;
  logic         r_refetch, w_refetch_d;
  logic         r_inv, w_inv_d;
  logic [3:0]   r_int_code, w_int_code_d;

  logic         w_req_active;
  logic [23:0]  w_word_addr;
  logic [23:0]  w_next_addr;
  logic [1:0]   w_len;
  logic         w_need2;
  logic [47:0]  w_ins;

  assign w_req_active = (r_state == StReq0) || (r_state == StReq1) || (r_state == StDrain);
  assign w_word_addr  = {r_iar[23:2], 2'b00};
  assign w_next_addr  = r_mem_addr + 24'd4;
  assign w_len        = ilen(r_iar[1] ? i_mem_data[15:14] : i_mem_data[31:30]);
  // Second word needed when the instruction outruns the bytes left in the first word.
  assign w_need2      = (w_len == 2'd3) || (r_iar[1] && (w_len != 2'd1));

  x2050_ins_align u_align (
    .i_word0 (r_word0),
    .i_word1 (r_word1),
    .i_iar1  (r_iar[1]),
    .i_ilc   (r_ilc),
    .o_ins   (w_ins)
  );

  // Next-state and datapath update; branch overrides whatever the state decided.
  always_comb begin
    w_state_d    = r_state;
    w_iar_d      = r_iar;
    w_mem_addr_d = r_mem_addr;
    w_t_reg_d    = r_t_reg;
    w_word0_d    = r_word0;
    w_word1_d    = r_word1;
    w_ilc_d      = r_ilc;
    w_refetch_d  = 1'b0;
    w_inv_d      = r_inv;
    w_int_code_d = r_int_code;

    unique case (r_state)
      StIdle: begin
        if (!i_hold) w_state_d = StCheck;
      end
      StCheck: begin
        if (r_iar[0]) begin
          w_state_d    = StFault;
          w_int_code_d = INT_SPECIFICATION;
        end else if (w_word_addr >= STORE_SIZE) begin
          w_state_d    = StFault;
          w_int_code_d = INT_ADDRESSING;
          w_inv_d      = 1'b1;
        end else begin
          w_mem_addr_d = w_word_addr;
          w_state_d    = StReq0;
        end
      end
      StReq0: begin
        if (i_mem_ack) begin
          w_t_reg_d = i_mem_data;
          w_word0_d = i_mem_data;
          w_word1_d = 32'h0;
          w_ilc_d   = w_len;
          if (!w_need2) begin
            w_state_d = StPresent;
          end else if (w_next_addr >= STORE_SIZE) begin
            w_state_d    = StFault;
            w_int_code_d = INT_ADDRESSING;
            w_inv_d      = 1'b1;
          end else begin
            w_mem_addr_d = w_next_addr;
            w_refetch_d  = 1'b1;
            w_state_d    = StReq1;
          end
        end
      end
      StReq1: begin
        if (i_mem_ack) begin
          w_t_reg_d = i_mem_data;
          w_word1_d = i_mem_data;
          w_state_d = StPresent;
        end
      end
      StPresent: begin
        if (i_ins_ready) begin
          w_iar_d   = r_iar + {21'b0, r_ilc, 1'b0};
          w_state_d = StIdle;
        end
      end
      StFault: ;
      StDrain: begin
        if (i_mem_ack) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    if (i_branch) begin
      w_iar_d      = i_branch_iar;
      w_t_reg_d    = r_t_reg;
      w_refetch_d  = 1'b0;
      w_inv_d      = 1'b0;
      w_int_code_d = 4'h0;
      // An issued request must still see its ack, so wait it out in DRAIN.
      w_state_d    = (w_req_active && !i_mem_ack) ? StDrain : StIdle;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_iar      <= 24'h0;
      r_mem_addr <= 24'h0;
      r_t_reg    <= 32'h0;
      r_word0    <= 32'h0;
      r_word1    <= 32'h0;
      r_ilc      <= 2'd0;
      r_refetch  <= 1'b0;
      r_inv      <= 1'b0;
      r_int_code <= 4'h0;
    end else begin
      r_state    <= w_state_d;
      r_iar      <= w_iar_d;
      r_mem_addr <= w_mem_addr_d;
      r_t_reg    <= w_t_reg_d;
      r_word0    <= w_word0_d;
      r_word1    <= w_word1_d;
      r_ilc      <= w_ilc_d;
      r_refetch  <= w_refetch_d;
      r_inv      <= w_inv_d;
      r_int_code <= w_int_code_d;
    end
  end

  assign o_mem_req         = w_req_active;
  assign o_mem_addr        = r_mem_addr;
  assign o_ins_valid       = (r_state == StPresent);
  assign o_ins             = (r_state == StPresent) ? w_ins : 48'h0;
  assign o_ilc             = (r_state == StPresent) ? r_ilc : 2'd0;
  assign o_iar             = r_iar;
  assign o_t_reg           = r_t_reg;
  assign o_invalid_address = r_inv;
  assign o_refetch         = r_refetch;
  assign o_pgm_int         = (r_state == StFault);
  assign o_int_code        = (r_state == StFault) ? r_int_code : 4'h0;

endmodule

// File: tb/tb_x2050_ifetch_seq.sv
// Directed bench for the instruction-fetch sequencer with a zero-latency storage responder.
module tb_x2050_ifetch_seq;

  logic        i_clk = 1'b0;
  logic        i_reset, i_branch, i_hold, i_mem_ack, i_ins_ready;
  logic [23:0] i_branch_iar;
  logic [31:0] i_mem_data;
  logic        o_mem_req, o_ins_valid, o_invalid_address, o_refetch, o_pgm_int;
  logic [23:0] o_mem_addr, o_iar;
  logic [47:0] o_ins;
  logic [1:0]  o_ilc;
  logic [31:0] o_t_reg;
  logic [3:0]  o_int_code;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int req_cyc = 0;
  int refetch_cnt = 0;
  int snap_ack, snap_req, snap_rf;
  bit block_en = 1'b0;
  logic [23:0] block_addr = 24'h0;
  logic [31:0] mem [logic [23:0]];

  always #5 i_clk = ~i_clk;

  x2050_ifetch_seq #(.STORE_SIZE(24'h040000)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_branch          (i_branch),
    .i_branch_iar      (i_branch_iar),
    .i_hold            (i_hold),
    .o_mem_req         (o_mem_req),
    .o_mem_addr        (o_mem_addr),
    .i_mem_ack         (i_mem_ack),
    .i_mem_data        (i_mem_data),
    .o_ins_valid       (o_ins_valid),
    .i_ins_ready       (i_ins_ready),
    .o_ins             (o_ins),
    .o_ilc             (o_ilc),
    .o_iar             (o_iar),
    .o_t_reg           (o_t_reg),
    .o_invalid_address (o_invalid_address),
    .o_refetch         (o_refetch),
    .o_pgm_int         (o_pgm_int),
    .o_int_code        (o_int_code)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Storage responder: acks any pending request at the negedge unless its address is blocked.
  initial begin
    i_mem_ack  = 1'b0;
    i_mem_data = 32'h0;
    forever begin
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      if (o_refetch) refetch_cnt++;
      if (o_mem_req) begin
        req_cyc++;
        if (!(block_en && (o_mem_addr == block_addr))) begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem.exists(o_mem_addr) ? mem[o_mem_addr] : 32'h0;
          ack_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic branch_to(input logic [23:0] addr);
    i_branch     = 1'b1;
    i_branch_iar = addr;
    step();
    i_branch = 1'b0;
  endtask

  task automatic accept();
    i_ins_ready = 1'b1;
    step();
    i_ins_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!o_ins_valid && n < 40) begin step(); n++; end
    check({tag, " valid_timeout"}, 64'(o_ins_valid), 64'd1);
  endtask

  task automatic wait_fault(input string tag);
    int n = 0;
    while (!o_pgm_int && n < 40) begin step(); n++; end
    check({tag, " fault_timeout"}, 64'(o_pgm_int), 64'd1);
  endtask

  task automatic wait_req(input string tag, input logic [23:0] addr);
    int n = 0;
    while (!(o_mem_req && o_mem_addr == addr) && n < 40) begin step(); n++; end
    check({tag, " req_timeout"}, 64'(o_mem_req && o_mem_addr == addr), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_branch = 1'b0; i_branch_iar = 24'h0; i_hold = 1'b1; i_ins_ready = 1'b0;
    mem[24'h000100] = 32'h1A23_BEEF;
    mem[24'h03FFFC] = 32'h0000_5812;
    mem[24'h000200] = 32'h0000_4510;
    mem[24'h000204] = 32'hFFFF_FFFF;
    mem[24'h000300] = 32'h0700_0000;
    step(); step();
    i_reset = 1'b0;
    step(); step();

    // Reset state, held idle by i_hold
    check("rst mem_req",   64'(o_mem_req), 64'd0);
    check("rst ins_valid", 64'(o_ins_valid), 64'd0);
    check("rst ins",       64'(o_ins), 64'd0);
    check("rst ilc",       64'(o_ilc), 64'd0);
    check("rst iar",       64'(o_iar), 64'd0);
    check("rst t_reg",     64'(o_t_reg), 64'd0);
    check("rst pgm_int",   64'(o_pgm_int), 64'd0);
    check("rst int_code",  64'(o_int_code), 64'd0);
    check("rst inv_addr",  64'(o_invalid_address), 64'd0);
    check("rst refetch",   64'(o_refetch), 64'd0);
    check("hold req_cyc",  64'(req_cyc), 64'd0);

    // RR at 0x100, aligned
    branch_to(24'h000100);
    i_hold = 1'b0;
    wait_valid("rr");
    check("rr ins",     64'(o_ins), 64'h1A23_0000_0000);
    check("rr ilc",     64'(o_ilc), 64'd1);
    check("rr iar",     64'(o_iar), 64'h100);
    check("rr t_reg",   64'(o_t_reg), 64'h1A23_BEEF);
    check("rr acks",    64'(ack_cnt), 64'd1);
    check("rr refetch", 64'(refetch_cnt), 64'd0);
    i_hold = 1'b1;
    step(); step();
    check("rr valid under hold", 64'(o_ins_valid), 64'd1);
    accept();
    check("rr next iar", 64'(o_iar), 64'h102);
    check("rr valid drop", 64'(o_ins_valid), 64'd0);

    // SS at 0x102, straddles into 0x104
    mem[24'h000100] = 32'h0000_D2FF;
    mem[24'h000104] = 32'h1000_2000;
    i_hold = 1'b0;
    wait_valid("ss");
    check("ss ins",     64'(o_ins), 64'hD2FF_1000_2000);
    check("ss ilc",     64'(o_ilc), 64'd3);
    check("ss acks",    64'(ack_cnt), 64'd3);
    check("ss refetch", 64'(refetch_cnt), 64'd1);
    check("ss t_reg",   64'(o_t_reg), 64'h1000_2000);
    i_hold = 1'b1;
    accept();
    check("ss next iar", 64'(o_iar), 64'h108);

    // Odd IAR: specification fault, no storage access
    snap_req = req_cyc;
    branch_to(24'h000101);
    i_hold = 1'b0;
    wait_fault("spec");
    step(); step(); step();
    check("spec pgm held", 64'(o_pgm_int), 64'd1);
    check("spec code",     64'(o_int_code), 64'h6);
    check("spec ilc",      64'(o_ilc), 64'd0);
    check("spec valid",    64'(o_ins_valid), 64'd0);
    check("spec inv_addr", 64'(o_invalid_address), 64'd0);
    check("spec no req",   64'(req_cyc), 64'(snap_req));

    // RX at top of storage: second word out of range
    snap_ack = ack_cnt;
    snap_rf  = refetch_cnt;
    branch_to(24'h03FFFE);
    check("br clears pgm",  64'(o_pgm_int), 64'd0);
    check("br clears code", 64'(o_int_code), 64'd0);
    wait_fault("addr");
    step(); step();
    check("addr code",     64'(o_int_code), 64'h5);
    check("addr inv_addr", 64'(o_invalid_address), 64'd1);
    check("addr one req",  64'(ack_cnt), 64'(snap_ack + 1));
    check("addr no refetch", 64'(refetch_cnt), 64'(snap_rf));
    check("addr t_reg",    64'(o_t_reg), 64'h0000_5812);
    check("addr req idle", 64'(o_mem_req), 64'd0);
    check("addr ilc",      64'(o_ilc), 64'd0);

    // Branch while the second-word request is outstanding
    block_addr = 24'h000204;
    block_en   = 1'b1;
    snap_ack   = ack_cnt;
    snap_rf    = refetch_cnt;
    branch_to(24'h000202);
    wait_req("drain", 24'h000204);
    check("drain refetch", 64'(refetch_cnt), 64'(snap_rf + 1));
    step(); step();
    check("drain req held", 64'(o_mem_req), 64'd1);
    branch_to(24'h000300);
    check("drain req kept", 64'(o_mem_req), 64'd1);
    check("drain addr kept", 64'(o_mem_addr), 64'h204);
    check("drain iar",      64'(o_iar), 64'h300);
    check("drain valid",    64'(o_ins_valid), 64'd0);
    check("drain acks",     64'(ack_cnt), 64'(snap_ack + 1));
    block_en = 1'b0;
    step(); step();
    check("drain ack taken", 64'(ack_cnt), 64'(snap_ack + 2));
    check("drain discard",   64'(o_t_reg), 64'h0000_4510);
    check("drain no valid",  64'(o_ins_valid), 64'd0);
    wait_valid("tgt");
    check("tgt ins",  64'(o_ins), 64'h0700_0000_0000);
    check("tgt ilc",  64'(o_ilc), 64'd1);
    check("tgt iar",  64'(o_iar), 64'h300);
    check("tgt acks", 64'(ack_cnt), 64'(snap_ack + 3));

    // Branch and accept in the same cycle: branch wins
    i_hold       = 1'b1;
    i_ins_ready  = 1'b1;
    i_branch     = 1'b1;
    i_branch_iar = 24'h000310;
    step();
    i_ins_ready = 1'b0;
    i_branch    = 1'b0;
    check("br+acc iar",   64'(o_iar), 64'h310);
    check("br+acc valid", 64'(o_ins_valid), 64'd0);

    // Asynchronous reset during REQ0
    block_addr = 24'h000310;
    block_en   = 1'b1;
    i_hold     = 1'b0;
    wait_req("arst", 24'h000310);
    #2;
    i_reset = 1'b1;
    #1;
    check("arst mem_req",  64'(o_mem_req), 64'd0);
    check("arst mem_addr", 64'(o_mem_addr), 64'd0);
    check("arst iar",      64'(o_iar), 64'd0);
    check("arst t_reg",    64'(o_t_reg), 64'd0);
    check("arst valid",    64'(o_ins_valid), 64'd0);
    check("arst ins",      64'(o_ins), 64'd0);
    check("arst code",     64'(o_int_code), 64'd0);
    i_hold = 1'b1;
    step();
    i_reset  = 1'b0;
    block_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
